ips_filter: RTL and testbench
=============================

# ips_filter

Conditions the three raw infrared proximity sensor (IPS) inputs before they reach the line-following drive controller. Each active-low sensor line is synchronised, debounced per channel, and presented as a clean active-high 3-bit pattern. The block also holds the last non-empty pattern and flags a sustained loss of tape. The drive controller's recovery logic consumes these signals directly and no longer keeps its own shadow of the sensor state.

## Interface
- DEBOUNCE_CYCLES, 100000: cycles a synchronised input must hold a new level before it is accepted (1 ms at 100 MHz); minimum 2.
- LOST_CYCLES, 20000000: consecutive cycles of `ips == 3'b000` before `lost` asserts (200 ms); minimum 2.
- clock  in  1  100 MHz system clock.
- reset_n  in  1  synchronous, active-low reset.
- ips_l_n, ips_c_n, ips_r_n  in  1 each  raw sensor lines, asynchronous; 0 = tape detected.
- ips  out  3  debounced pattern, active-high, {L, C, R} = bits [2:0].
- ips_valid  out  1  high once start-up settling completes.
- ips_change  out  1  one-cycle pulse on the cycle `ips` takes a new value (TRACK/LOST only).
- last_seen  out  3  most recent non-zero value of `ips`.
- lost  out  1  tape lost for at least LOST_CYCLES.

## Operation
- Input path: each raw line is inverted, then passed through a 2-flop synchroniser. The synchroniser output is `s[i]`.
- Debounce, per channel i, with filtered bit `f[i]` and counter `dc[i]`:
  - If `s[i] == f[i]`: clear `dc[i]`.
  - Otherwise increment `dc[i]`. When `dc[i]` reaches DEBOUNCE_CYCLES-1, load `f[i] <= s[i]` and clear `dc[i]`.
  - A bounce back before the count completes clears `dc[i]`, so no partial credit carries over.
- Control FSM states: INIT, TRACK, LOST.
  - INIT (reset state):
    - `f` loads `s` every cycle.
    - A shared counter increments while `s` is unchanged from the previous cycle and clears on any change.
    - When the counter reaches DEBOUNCE_CYCLES-1, go to TRACK and set `ips_valid=1`, `ips <= f`, and `last_seen <= f` if `f` is non-zero.
    - No `ips_change` pulse is issued on this transition.
  - TRACK:
    - Per-channel debounce is active and `ips` follows `f`.
    - A lost counter increments while `ips == 0` and clears otherwise.
    - When the lost counter reaches LOST_CYCLES-1, go to LOST and set `lost=1`.
  - LOST:
    - Debounce continues and `ips` keeps following `f`.
    - On the edge where `ips` becomes non-zero: go to TRACK, clear `lost`, clear the lost counter, pulse `ips_change`.
- `last_seen` loads the new value on any update of `ips` to a non-zero value. It holds its value while `ips == 0`.
- `ips_change` pulses whenever the new `ips` differs from the old value in TRACK or LOST. If several channels settle on the same cycle, the result is one pulse.
- Counters use width `$clog2(param)` and must not wrap: the compare-and-clear happens before overflow.
- Reset values: `ips=0`, `ips_valid=0`, `ips_change=0`, `last_seen=0`, `lost=0`, all counters 0, `f=0`, synchronisers 0, state INIT.
- Reset asserted mid-operation returns the block to INIT on the next edge. `ips_valid` drops and settling restarts.

## Timing
- Raw edge to `s`: 2 edges.
- `s` change to `f`/`ips` update: DEBOUNCE_CYCLES edges, provided the level is held.
- Total raw-to-`ips` latency: DEBOUNCE_CYCLES+2 edges.
- `ips_change`, `last_seen` and `lost` update on the same edge as `ips`. All outputs are registered.
- After reset release on a quiet input, `ips_valid` rises DEBOUNCE_CYCLES+2 edges later.
- `lost` rises LOST_CYCLES edges after `ips` becomes 0. It falls on the edge `ips` becomes non-zero.

## Structure
- Shared package: FSM state enum (INIT/TRACK/LOST) and the IPS bit-index constants L=2, C=1, R=0. The drive controller imports the same constants.
- Sub-module `ips_debounce_ch` (one channel: synchroniser, counter, filtered bit), instantiated three times. FSM, lost counter and output registers live in `ips_filter`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, LOST_CYCLES=10.
- Reset release with all raw lines at 1 → `ips_valid` rises 6 edges later; `ips=000`, `ips_change=0`, `lost=0`.
- From valid, `ips_c_n` 1→0 held → `ips=010` and a 1-cycle `ips_change` exactly 6 edges after the edge; `last_seen=010`.
- `ips_r_n` pulses low for 3 cycles → `ips` unchanged, no `ips_change`. A 4-cycle pulse → `ips=001`.
- `ips=010`, then all lines go high → `ips=000` after 6 edges, `last_seen` stays 010, `lost=1` 10 edges later. `ips_l_n` then low → `ips=100` and `lost=0` on the same edge, `ips_change` pulses, `last_seen=100`.
- `ips_l_n` and `ips_r_n` fall on the same cycle → `ips=101` with a single `ips_change` pulse.
- `reset_n` low for 1 cycle while `lost=1` → all outputs return to 0 next edge and INIT settling restarts.

Source files
------------

// File: rtl/ips_filter_pkg.sv
// ---------------------------------------------------------------------------
// ips_filter_pkg
// Shared definitions for the IPS sensor conditioning path and the drive
// controller that consumes its outputs.
//   ips_state_e   : control FSM states of ips_filter
//   IPS_L/C/R     : bit positions of the left/centre/right sensor in `ips`
//   cnt_width()   : counter width for a "count to N-1" counter
// ---------------------------------------------------------------------------
package ips_filter_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_LOST  = 2'd2
  } ips_state_e;

  localparam int unsigned IPS_W = 3;
  localparam int unsigned IPS_L = 2;
  localparam int unsigned IPS_C = 1;
  localparam int unsigned IPS_R = 0;

  // A counter that only has to reach n-1 before it is cleared fits in
  // $clog2(n) bits; never return zero so the vector stays legal.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ips_debounce_ch.sv
// ---------------------------------------------------------------------------
// ips_debounce_ch
// One sensor channel: inversion, 2-flop synchroniser, per-channel debounce
// counter and the filtered bit.
// Ports:
//   clock          in   system clock
//   reset_n        in   synchronous active-low reset
//   raw_n_i        in   raw asynchronous sensor line, 0 = tape
//   debounce_en_i  in   1: debounce active, 0: filtered bit tracks s directly
//   filt_o         out  filtered bit (registered)
//   filt_next_o    out  value the filtered bit takes on the next edge
// ---------------------------------------------------------------------------
module ips_debounce_ch
  import ips_filter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw_n_i,
  input  logic debounce_en_i,
  output logic filt_o,
  output logic filt_next_o
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DC_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync_q;
  logic          filt_q;
  logic          filt_d;
  logic [CW-1:0] dbCnt_q;
  logic [CW-1:0] dbCnt_d;

  // Debounce: a differing level must persist until the counter reaches its
  // last value; any bounce back clears the count so no partial credit
  // survives. While disabled the filtered bit simply shadows the
  // synchroniser so that enabling starts from the current input level.
  always_comb begin
    filt_d  = filt_q;
    dbCnt_d = '0;
    if (!debounce_en_i) begin
      filt_d = sync_q;
    end else if (sync_q != filt_q) begin
      if (dbCnt_q == DC_LAST) begin
        filt_d = sync_q;
      end else begin
        dbCnt_d = dbCnt_q + CW'(1);
      end
    end
  end

  // Inverting synchroniser plus debounce state.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync_q  <= 1'b0;
      filt_q  <= 1'b0;
      dbCnt_q <= '0;
    end else begin
      sync1_q <= ~raw_n_i;
      sync_q  <= sync1_q;
      filt_q  <= filt_d;
      dbCnt_q <= dbCnt_d;
    end
  end

  assign filt_o      = filt_q;
  assign filt_next_o = filt_d;

endmodule

// File: rtl/ips_filter.sv
// ---------------------------------------------------------------------------
// ips_filter
// Conditions the three active-low IPS lines into a debounced active-high
// pattern, remembers the last non-empty pattern and flags sustained tape loss.
// Ports:
//   clock                      in   100 MHz system clock
//   reset_n                    in   synchronous active-low reset
//   ips_l_n, ips_c_n, ips_r_n  in   raw sensor lines, 0 = tape detected
//   ips[2:0]                   out  debounced pattern {L, C, R}
//   ips_valid                  out  start-up settling complete
//   ips_change                 out  one-cycle pulse when ips changes
//   last_seen[2:0]             out  most recent non-zero ips
//   lost                       out  ips has been 0 for LOST_CYCLES cycles
// ---------------------------------------------------------------------------
module ips_filter
  import ips_filter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned LOST_CYCLES     = 20000000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ips_l_n,
  input  logic             ips_c_n,
  input  logic             ips_r_n,
  output logic [IPS_W-1:0] ips,
  output logic             ips_valid,
  output logic             ips_change,
  output logic [IPS_W-1:0] last_seen,
  output logic             lost
);

  localparam int unsigned SW = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned LW = cnt_width(LOST_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LOST_LAST   = LW'(LOST_CYCLES - 1);

  logic [IPS_W-1:0] rawN;
  logic [IPS_W-1:0] filt_q;
  logic [IPS_W-1:0] filt_d;
  logic             debounceEn;

  ips_state_e       state_q,     state_d;
  logic [1:0]       primed_q,    primed_d;
  logic [SW-1:0]    settleCnt_q, settleCnt_d;
  logic [LW-1:0]    lostCnt_q,   lostCnt_d;
  logic [IPS_W-1:0] ips_q,       ips_d;
  logic             valid_q,     valid_d;
  logic             change_q,    change_d;
  logic [IPS_W-1:0] last_q,      last_d;
  logic             lost_q,      lost_d;

  assign rawN[IPS_L] = ips_l_n;
  assign rawN[IPS_C] = ips_c_n;
  assign rawN[IPS_R] = ips_r_n;

  assign debounceEn = (state_q != ST_INIT);

  for (genvar i = 0; i < IPS_W; i++) begin : g_ch
    ips_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clock         (clock),
      .reset_n       (reset_n),
      .raw_n_i       (rawN[i]),
      .debounce_en_i (debounceEn),
      .filt_o        (filt_q[i]),
      .filt_next_o   (filt_d[i])
    );
  end

  // Control FSM. In INIT the filtered bits shadow the synchronisers, so
  // "s unchanged since last cycle" is simply filt_d == filt_q. The settle
  // window only opens once primed_q shows the synchronisers have been
  // refilled with real samples after reset, giving the DEBOUNCE_CYCLES+2
  // start-up time. In TRACK/LOST, ips is loaded with filt_d so that it
  // moves on the same edge as the filtered bits.
  always_comb begin
    state_d     = state_q;
    primed_d    = {primed_q[0], 1'b1};
    settleCnt_d = settleCnt_q;
    lostCnt_d   = lostCnt_q;
    ips_d       = ips_q;
    valid_d     = valid_q;
    change_d    = 1'b0;
    last_d      = last_q;
    lost_d      = lost_q;
    unique case (state_q)
      ST_INIT: begin
        if (!primed_q[1] || (filt_d != filt_q)) begin
          settleCnt_d = '0;
        end else if (settleCnt_q == SETTLE_LAST) begin
          settleCnt_d = '0;
          state_d     = ST_TRACK;
          valid_d     = 1'b1;
          ips_d       = filt_d;
          if (filt_d != '0) last_d = filt_d;
        end else begin
          settleCnt_d = settleCnt_q + SW'(1);
        end
      end
      ST_TRACK: begin
        ips_d    = filt_d;
        change_d = (filt_d != ips_q);
        if (filt_d != '0) last_d = filt_d;
        if ((ips_q != '0) || (filt_d != '0)) begin
          lostCnt_d = '0;
        end else if (lostCnt_q == LOST_LAST) begin
          lostCnt_d = '0;
          state_d   = ST_LOST;
          lost_d    = 1'b1;
        end else begin
          lostCnt_d = lostCnt_q + LW'(1);
        end
      end
      ST_LOST: begin
        ips_d = filt_d;
        if (filt_d != '0) begin
          state_d   = ST_TRACK;
          lost_d    = 1'b0;
          lostCnt_d = '0;
          change_d  = 1'b1;
          last_d    = filt_d;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      primed_q    <= '0;
      settleCnt_q <= '0;
      lostCnt_q   <= '0;
      ips_q       <= '0;
      valid_q     <= 1'b0;
      change_q    <= 1'b0;
      last_q      <= '0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      primed_q    <= primed_d;
      settleCnt_q <= settleCnt_d;
      lostCnt_q   <= lostCnt_d;
      ips_q       <= ips_d;
      valid_q     <= valid_d;
      change_q    <= change_d;
      last_q      <= last_d;
      lost_q      <= lost_d;
    end
  end

  assign ips        = ips_q;
  assign ips_valid  = valid_q;
  assign ips_change = change_q;
  assign last_seen  = last_q;
  assign lost       = lost_q;

endmodule

// File: tb/tb_ips_filter.sv
// ---------------------------------------------------------------------------
// tb_ips_filter
// Self-checking bench for ips_filter with DEBOUNCE_CYCLES=4, LOST_CYCLES=10.
// Each scenario task drives the raw lines, checks timing inline and pushes
// the expected post-update state onto a queue; a monitor pops one entry for
// every ips_change pulse and compares ips/last_seen/lost.
// ---------------------------------------------------------------------------
module tb_ips_filter;

  localparam int unsigned DEB  = 4;
  localparam int unsigned LOST = 10;

  typedef struct packed {
    logic [2:0] ips;
    logic [2:0] last;
    logic       lost;
  } exp_t;

  logic       clock;
  logic       reset_n;
  logic       ips_l_n, ips_c_n, ips_r_n;
  logic [2:0] ips;
  logic       ips_valid;
  logic       ips_change;
  logic [2:0] last_seen;
  logic       lost;

  int   assertions = 0;
  int   failures   = 0;
  exp_t expQ[$];

  ips_filter #(
    .DEBOUNCE_CYCLES(DEB),
    .LOST_CYCLES    (LOST)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .ips_l_n   (ips_l_n),
    .ips_c_n   (ips_c_n),
    .ips_r_n   (ips_r_n),
    .ips       (ips),
    .ips_valid (ips_valid),
    .ips_change(ips_change),
    .last_seen (last_seen),
    .lost      (lost)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard monitor: every ips_change pulse consumes one expectation.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (ips_change === 1'b1) begin
      assertions++;
      if (expQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL sb_unexpected_change: ips=%b, no update expected", ips);
      end else begin
        e = expQ.pop_front();
        if (ips !== e.ips) begin
          failures++;
          $display("[TB] FAIL sb_ips: got %b expected %b", ips, e.ips);
        end
        assertions++;
        if (last_seen !== e.last) begin
          failures++;
          $display("[TB] FAIL sb_last_seen: got %b expected %b", last_seen, e.last);
        end
        assertions++;
        if (lost !== e.lost) begin
          failures++;
          $display("[TB] FAIL sb_lost: got %b expected %b", lost, e.lost);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    assertions++;
    if ({ips, ips_valid, ips_change, last_seen, lost} !== 9'b0) begin
      failures++;
      $display("[TB] FAIL %s: ips=%b valid=%b change=%b last=%b lost=%b expected all 0",
               tag, ips, ips_valid, ips_change, last_seen, lost);
    end
  endtask

  // Counts edges until ips_valid, bounded.
  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (ips_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    assertions++;
    if (n != DEB + 2) begin
      failures++;
      $display("[TB] FAIL %s: ips_valid after %0d edges expected %0d", tag, n, DEB + 2);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ips_l_n = 1'b1; ips_c_n = 1'b1; ips_r_n = 1'b1;
    repeat (3) tick();
    check_outputs_zero("reset_state");
    reset_n = 1'b1;
    wait_valid("settle_latency");
    assertions++;
    if (ips !== 3'b000 || ips_change !== 1'b0 || lost !== 1'b0) begin
      failures++;
      $display("[TB] FAIL settle_outputs: ips=%b change=%b lost=%b expected 000/0/0",
               ips, ips_change, lost);
    end
  endtask

  task automatic test_single_channel();
    ips_c_n = 1'b0;
    expQ.push_back('{ips: 3'b010, last: 3'b010, lost: 1'b0});
    for (int k = 1; k <= DEB + 2; k++) begin
      tick();
      if (k < DEB + 2) begin
        assertions++;
        if (ips !== 3'b000 || ips_change !== 1'b0) begin
          failures++;
          $display("[TB] FAIL centre_early: edge %0d ips=%b change=%b expected 000/0", k, ips, ips_change);
        end
      end
    end
    assertions++;
    if (ips !== 3'b010 || ips_change !== 1'b1) begin
      failures++;
      $display("[TB] FAIL centre_latency: ips=%b change=%b expected 010/1", ips, ips_change);
    end
    tick();
    assertions++;
    if (ips_change !== 1'b0) begin
      failures++;
      $display("[TB] FAIL centre_pulse_width: change=%b expected 0", ips_change);
    end
  endtask

  task automatic test_glitch_reject();
    ips_r_n = 1'b0;
    repeat (3) tick();
    ips_r_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      assertions++;
      if (ips !== 3'b010 || ips_change !== 1'b0) begin
        failures++;
        $display("[TB] FAIL glitch_3cyc: ips=%b change=%b expected 010/0", ips, ips_change);
      end
    end
    // A 4-cycle pulse is accepted and then its release is accepted as well.
    expQ.push_back('{ips: 3'b011, last: 3'b011, lost: 1'b0});
    expQ.push_back('{ips: 3'b010, last: 3'b010, lost: 1'b0});
    ips_r_n = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 4) ips_r_n = 1'b1;
      if (k == 6) begin
        assertions++;
        if (ips !== 3'b011) begin
          failures++;
          $display("[TB] FAIL pulse_4cyc: ips=%b expected 011", ips);
        end
      end
      if (k == 10) begin
        assertions++;
        if (ips !== 3'b010) begin
          failures++;
          $display("[TB] FAIL pulse_release: ips=%b expected 010", ips);
        end
      end
    end
  endtask

  task automatic test_lost_recovery();
    ips_c_n = 1'b1;
    expQ.push_back('{ips: 3'b000, last: 3'b010, lost: 1'b0});
    repeat (DEB + 2) tick();
    assertions++;
    if (ips !== 3'b000 || last_seen !== 3'b010 || lost !== 1'b0) begin
      failures++;
      $display("[TB] FAIL tape_gone: ips=%b last=%b lost=%b expected 000/010/0", ips, last_seen, lost);
    end
    for (int k = 1; k <= LOST; k++) begin
      tick();
      if (k == LOST - 1) begin
        assertions++;
        if (lost !== 1'b0) begin
          failures++;
          $display("[TB] FAIL lost_early: lost=%b expected 0", lost);
        end
      end
    end
    assertions++;
    if (lost !== 1'b1) begin
      failures++;
      $display("[TB] FAIL lost_rise: lost=%b expected 1", lost);
    end
    ips_l_n = 1'b0;
    expQ.push_back('{ips: 3'b100, last: 3'b100, lost: 1'b0});
    for (int k = 1; k <= DEB + 2; k++) begin
      tick();
      if (k == DEB + 1) begin
        assertions++;
        if (lost !== 1'b1 || ips !== 3'b000) begin
          failures++;
          $display("[TB] FAIL lost_hold: lost=%b ips=%b expected 1/000", lost, ips);
        end
      end
    end
    assertions++;
    if (ips !== 3'b100 || lost !== 1'b0 || ips_change !== 1'b1 || last_seen !== 3'b100) begin
      failures++;
      $display("[TB] FAIL recover: ips=%b lost=%b change=%b last=%b expected 100/0/1/100",
               ips, lost, ips_change, last_seen);
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    ips_l_n = 1'b1;
    expQ.push_back('{ips: 3'b000, last: 3'b100, lost: 1'b0});
    repeat (DEB + 2) tick();
    ips_l_n = 1'b0;
    ips_r_n = 1'b0;
    expQ.push_back('{ips: 3'b101, last: 3'b101, lost: 1'b0});
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (ips_change === 1'b1) pulses++;
      if (k == DEB + 2) begin
        assertions++;
        if (ips !== 3'b101) begin
          failures++;
          $display("[TB] FAIL simultaneous_ips: ips=%b expected 101", ips);
        end
      end
    end
    assertions++;
    if (pulses != 1) begin
      failures++;
      $display("[TB] FAIL simultaneous_pulses: %0d pulses expected 1", pulses);
    end
  endtask

  task automatic test_reset_midop();
    int n;
    ips_l_n = 1'b1;
    ips_r_n = 1'b1;
    expQ.push_back('{ips: 3'b000, last: 3'b101, lost: 1'b0});
    repeat (DEB + 2) tick();
    n = 0;
    while (lost !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    assertions++;
    if (lost !== 1'b1 || n != LOST) begin
      failures++;
      $display("[TB] FAIL lost_before_reset: lost=%b after %0d edges expected 1 after %0d", lost, n, LOST);
    end
    reset_n = 1'b0;
    tick();
    check_outputs_zero("midop_reset");
    reset_n = 1'b1;
    wait_valid("resettle_latency");
  endtask

  initial begin
    $display("[TB] start ips_filter bench");
    test_reset();
    test_single_channel();
    test_glitch_reject();
    test_lost_recovery();
    test_back_to_back();
    test_reset_midop();
    repeat (2) tick();
    assertions++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL sb_drain: %0d expected updates never seen, expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
